// File: rtl/gpio_pkg.sv
// gpio_pkg -- shared definitions for the GPIO bridge.
//   Register byte offsets within the 7-word window, the window size,
//   the bridge FSM state encoding, the internal register-select code and
//   a byte-enable expansion helper.
package gpio_pkg;

  localparam int          WIN_WORDS = 7;
  localparam logic [31:0] WIN_BYTES = 32'd28;

  // Register byte offsets relative to BASE_ADDR.
  localparam logic [4:0] OFF_STATE = 5'h00;  // RO
  localparam logic [4:0] OFF_OUT   = 5'h04;  // RW
  localparam logic [4:0] OFF_SET   = 5'h08;  // WO
  localparam logic [4:0] OFF_CLR   = 5'h0C;  // WO
  localparam logic [4:0] OFF_TOG   = 5'h10;  // WO
  localparam logic [4:0] OFF_RISE  = 5'h14;  // RW1C
  localparam logic [4:0] OFF_IEN   = 5'h18;  // RW

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_STATE = 3'd0,
    SEL_OUT   = 3'd1,
    SEL_SET   = 3'd2,
    SEL_CLR   = 3'd3,
    SEL_TOG   = 3'd4,
    SEL_RISE  = 3'd5,
    SEL_IEN   = 3'd6,
    SEL_ERR   = 3'd7
  } reg_sel_t;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_edge_detect.sv
// gpio_edge_detect -- rising-edge capture and interrupt generation.
//   Keeps the previous device state, the sticky RISE register (write-1-to-clear),
//   the IEN enable register and a registered level interrupt.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dev_state       current GPIO device state
//   rise_clr        per-bit clear mask for RISE (already qualified by wstrb)
//   ien_we          IEN write strobe
//   ien_wmask       per-bit write mask for IEN (from wstrb)
//   ien_wdata       IEN write data
//   rise, ien       register contents
//   irq             registered |(RISE & IEN)
module gpio_edge_detect
  import gpio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dev_state,
  input  logic [31:0] rise_clr,
  input  logic        ien_we,
  input  logic [31:0] ien_wmask,
  input  logic [31:0] ien_wdata,
  output logic [31:0] rise,
  output logic [31:0] ien,
  output logic        irq
);

  logic [31:0] prev;
  logic [31:0] new_edges;

  assign new_edges = dev_state & ~prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Sampling the live state in reset keeps pins that are already high
      // from reporting a spurious edge once reset drops.
      prev <= dev_state;
      rise <= '0;
      ien  <= '0;
      irq  <= 1'b0;
    end else begin
      prev <= dev_state;
      // Clear first, then OR in new edges: a coincident edge wins.
      rise <= (rise & ~rise_clr) | new_edges;
      if (ien_we) begin
        ien <= (ien & ~ien_wmask) | (ien_wdata & ien_wmask);
      end
      irq  <= |(rise & ien);
    end
  end

endmodule

// File: rtl/gpio_bridge.sv
// gpio_bridge -- CPU register window onto a GPIO device write port.
//   Stores go IDLE -> DRIVE -> SETTLE -> RESP (3-cycle latency); loads and
//   decode errors go IDLE -> RESP (1-cycle latency).
//   Optional feature macro: GPIO_BRIDGE_IRQ_EN adds RISE/IEN registers and
//   the level interrupt (gpio_edge_detect); without it 0x14/0x18 decode as
//   errors and irq_Out is 0.
// Handshake: a request is taken when req_In=1 while the FSM is IDLE; all
//   request inputs are latched then and ignored in every other state.
//   ready_Out pulses for one cycle; err_Out and rdata_Out are meaningful only
//   in that cycle and are 0 otherwise.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_In, we_In, addr_In, wdata_In, wstrb_In   CPU request
//   ready_Out, rdata_Out, err_Out     CPU response
//   devMask_Out, devValue_Out         device write port (non-zero only in DRIVE)
//   devState_In                       current device state
//   irq_Out                           level interrupt
//   state_dbg                         current FSM state (gpio_pkg::state_t)
module gpio_bridge
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_In,
  input  logic        we_In,
  input  logic [31:0] addr_In,
  input  logic [31:0] wdata_In,
  input  logic [3:0]  wstrb_In,
  output logic        ready_Out,
  output logic [31:0] rdata_Out,
  output logic        err_Out,
  output logic [31:0] devMask_Out,
  output logic [31:0] devValue_Out,
  input  logic [31:0] devState_In,
  output logic        irq_Out,
  output logic [1:0]  state_dbg
);

  state_t      state, state_nxt;
  reg_sel_t    sel_dec, sel_q;
  logic        we_q, err_q, err_dec;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] offset;
  logic [31:0] rise_val, ien_val;

  assign state_dbg = state;

  // Address decode: only aligned offsets of the defined registers are valid.
  assign offset = addr_In - BASE_ADDR;

  always_comb begin
    sel_dec = SEL_ERR;
    if (offset < WIN_BYTES) begin
      case (offset[4:0])
        OFF_STATE: sel_dec = SEL_STATE;
        OFF_OUT:   sel_dec = SEL_OUT;
        OFF_SET:   sel_dec = SEL_SET;
        OFF_CLR:   sel_dec = SEL_CLR;
        OFF_TOG:   sel_dec = SEL_TOG;
`ifdef GPIO_BRIDGE_IRQ_EN
        OFF_RISE:  sel_dec = SEL_RISE;
        OFF_IEN:   sel_dec = SEL_IEN;
`endif
        default:   sel_dec = SEL_ERR;
      endcase
    end
  end

  // Stores to the read-only STATE register are errors as well.
  assign err_dec = (sel_dec == SEL_ERR) || (we_In && (sel_dec == SEL_STATE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_In) begin
          state_nxt = (we_In && !err_dec) ? ST_DRIVE : ST_RESP;
        end
      end
      ST_DRIVE:  state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_q   <= SEL_ERR;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_In) begin
        sel_q   <= sel_dec;
        we_q    <= we_In;
        err_q   <= err_dec;
        wdata_q <= wdata_In;
        wstrb_q <= wstrb_In;
      end
    end
  end

  // Device write port. Everything is gated by rst so a reset cycle shows all
  // outputs at 0 immediately, not one edge later.
  always_comb begin
    devMask_Out  = '0;
    devValue_Out = '0;
    if (state == ST_DRIVE && !rst) begin
      case (sel_q)
        SEL_OUT: begin
          devMask_Out  = strb_mask(wstrb_q);
          devValue_Out = wdata_q;
        end
        SEL_SET: begin
          devMask_Out  = wdata_q;
          devValue_Out = '1;
        end
        SEL_CLR: begin
          devMask_Out  = wdata_q;
          devValue_Out = '0;
        end
        SEL_TOG: begin
          devMask_Out  = wdata_q;
          devValue_Out = ~devState_In;
        end
        default: begin
          devMask_Out  = '0;
          devValue_Out = '0;
        end
      endcase
    end
  end

  // Response.
  assign ready_Out = (state == ST_RESP) && !rst;
  assign err_Out   = ready_Out && err_q;

  always_comb begin
    rdata_Out = '0;
    if (ready_Out && !err_q && !we_q) begin
      case (sel_q)
        SEL_STATE, SEL_OUT: rdata_Out = devState_In;
        SEL_RISE:           rdata_Out = rise_val;
        SEL_IEN:            rdata_Out = ien_val;
        default:            rdata_Out = '0;
      endcase
    end
  end

`ifdef GPIO_BRIDGE_IRQ_EN
  logic [31:0] rise_clr;
  logic        ien_we;
  logic        irq_q;

  // Register writes take effect at the end of the DRIVE cycle, like device writes.
  assign rise_clr = (state == ST_DRIVE && sel_q == SEL_RISE) ?
                    (wdata_q & strb_mask(wstrb_q)) : '0;
  assign ien_we   = (state == ST_DRIVE) && (sel_q == SEL_IEN);

  gpio_edge_detect u_edge (
    .clk       (clk),
    .rst       (rst),
    .dev_state (devState_In),
    .rise_clr  (rise_clr),
    .ien_we    (ien_we),
    .ien_wmask (strb_mask(wstrb_q)),
    .ien_wdata (wdata_q),
    .rise      (rise_val),
    .ien       (ien_val),
    .irq       (irq_q)
  );

  assign irq_Out = irq_q && !rst;
`else
  assign rise_val = '0;
  assign ien_val  = '0;
  assign irq_Out  = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_bridge.sv
// tb_gpio_bridge -- directed bench for gpio_bridge with a response
// scoreboard and a device-write scoreboard fed by a negedge monitor.
module tb_gpio_bridge;
  import gpio_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] dev_mask, dev_value;
  logic [31:0] dev_state = '0;
  logic [31:0] ext_set = '0;
  logic        irq;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q[$];    // {err, rdata}
  logic [63:0] drv_q[$];    // {mask, value}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  gpio_bridge #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_In       (req),
    .we_In        (we),
    .addr_In      (addr),
    .wdata_In     (wdata),
    .wstrb_In     (wstrb),
    .ready_Out    (ready),
    .rdata_Out    (rdata),
    .err_Out      (err),
    .devMask_Out  (dev_mask),
    .devValue_Out (dev_value),
    .devState_In  (dev_state),
    .irq_Out      (irq),
    .state_dbg    (state_dbg)
  );

  // Simple GPIO device: masked write, plus an external pin-set input.
  always @(posedge clk) begin
    dev_state <= ((dev_state & ~dev_mask) | (dev_value & dev_mask)) | ext_set;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    logic [63:0] d;
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {31'd0, ready}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", rdata, e[31:0]);
        check("resp_err", {31'd0, err}, {31'd0, e[32]});
      end
    end
    if (dev_mask != 0 || dev_value != 0) begin
      if (drv_q.size() == 0) begin
        check("unexpected_drive", dev_mask, 32'd0);
      end else begin
        d = drv_q.pop_front();
        check("drive_mask", dev_mask, d[63:32]);
        check("drive_value", dev_value, d[31:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at #1 after a posedge with the FSM in IDLE; returns the same way.
  task automatic issue(input logic w, input logic [31:0] off, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err,
                       input logic has_drv, input logic [31:0] exp_mask,
                       input logic [31:0] exp_val, input int exp_lat, input logic [31:0] ext);
    int n;
    exp_q.push_back({exp_err, exp_rd});
    if (has_drv) drv_q.push_back({exp_mask, exp_val});
    we = w; addr = BASE + off; wdata = d; wstrb = s; req = 1'b1; ext_set = ext;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; ext_set = '0;
    n = 1;
    while (!ready && n <= 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mask", dev_mask, 32'd0);
    check("rst_value", dev_value, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    rst = 1'b0;
    @(posedge clk); #1;

    // SET 0x5 from state 0
    issue(1, 32'h08, 32'h0000_0005, 4'hF, 32'h0, 0, 1, 32'h5, 32'hFFFF_FFFF, 3, 0);
    issue(0, 32'h00, 32'h0, 4'hF, 32'h5, 0, 0, 0, 0, 1, 0);
    // OUT with a single byte lane enabled
    issue(1, 32'h04, 32'hAABB_CCDD, 4'b0010, 32'h0, 0, 1, 32'h0000_FF00, 32'hAABB_CCDD, 3, 0);
    issue(0, 32'h04, 32'h0, 4'hF, 32'h0000_CC05, 0, 0, 0, 0, 1, 0);
    // CLR all, SET bit0, TOG 0x3 -> state 0x2
    issue(1, 32'h0C, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 1, 32'hFFFF_FFFF, 32'h0, 3, 0);
    issue(1, 32'h08, 32'h1, 4'hF, 32'h0, 0, 1, 32'h1, 32'hFFFF_FFFF, 3, 0);
    issue(1, 32'h10, 32'h3, 4'hF, 32'h0, 0, 1, 32'h3, 32'hFFFF_FFFE, 3, 0);
    issue(0, 32'h00, 32'h0, 4'hF, 32'h2, 0, 0, 0, 0, 1, 0);
    // Load of a write-only register, errors
    issue(0, 32'h08, 32'h0, 4'hF, 32'h0, 0, 0, 0, 0, 1, 0);
    issue(0, 32'h1C, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 1, 0);
    issue(1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 0, 0, 1, 0);
    issue(0, 32'h1000_0000, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 1, 0);
    issue(0, 32'h02, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 1, 0);
`ifndef GPIO_BRIDGE_IRQ_EN
    issue(0, 32'h14, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 1, 0);
    issue(1, 32'h18, 32'h1, 4'hF, 32'h0, 1, 0, 0, 0, 1, 0);
`endif

    // Back-to-back: req held across two loads gives two pulses.
    exp_q.push_back({1'b0, 32'h2});
    exp_q.push_back({1'b0, 32'h2});
    we = 1'b0; addr = BASE; req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    req = 1'b0;
    check("b2b_pulses", pulses, 32'd2);
    @(posedge clk); #1;

    // Reset during SETTLE aborts the response; the device write already happened.
    drv_q.push_back({32'h10, 32'hFFFF_FFFF});
    we = 1'b1; addr = BASE + 32'h08; wdata = 32'h10; wstrb = 4'hF; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("settle_state", {30'd0, state_dbg}, {30'd0, ST_SETTLE});
    rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_mask", dev_mask, 32'd0);
    check("abort_value", dev_value, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
    issue(0, 32'h00, 32'h0, 4'hF, 32'h12, 0, 0, 0, 0, 1, 0);

`ifdef GPIO_BRIDGE_IRQ_EN
    issue(1, 32'h18, 32'h1, 4'hF, 32'h0, 0, 0, 0, 0, 3, 0);
    issue(0, 32'h18, 32'h0, 4'hF, 32'h1, 0, 0, 0, 0, 1, 0);
    issue(1, 32'h08, 32'h1, 4'hF, 32'h0, 0, 1, 32'h1, 32'hFFFF_FFFF, 3, 0);
    check("irq_set", {31'd0, irq}, 32'd1);
    issue(0, 32'h14, 32'h0, 4'hF, 32'h1, 0, 0, 0, 0, 1, 0);
    issue(1, 32'h0C, 32'h1, 4'hF, 32'h0, 0, 1, 32'h1, 32'h0, 3, 0);
    // W1C of bit0 coinciding with a fresh bit0 edge: bit stays set.
    issue(1, 32'h14, 32'h1, 4'hF, 32'h0, 0, 0, 0, 0, 3, 32'h1);
    issue(0, 32'h14, 32'h0, 4'hF, 32'h1, 0, 0, 0, 0, 1, 0);
    check("irq_hold", {31'd0, irq}, 32'd1);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_empty", exp_q.size(), 32'd0);
    check("drive_queue_empty", drv_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
